// File: rtl/pp_accum.sv
// Partial-product accumulator: sums a 3x4 grid of 26x20-bit partial products
// into the 156-bit product of two 78-bit operands, one grid row per cycle.
module pp_accum #(
  parameter int RADIX = 78,
  parameter int PW    = 46
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PW-1:0]      res_0,
  input  logic [PW-1:0]      res_1,
  input  logic [PW-1:0]      res_2,
  input  logic [PW-1:0]      res_3,
  input  logic [PW-1:0]      res_4,
  input  logic [PW-1:0]      res_5,
  input  logic [PW-1:0]      res_6,
  input  logic [PW-1:0]      res_7,
  input  logic [PW-1:0]      res_8,
  input  logic [PW-1:0]      res_9,
  input  logic [PW-1:0]      res_10,
  input  logic [PW-1:0]      res_11,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*RADIX-1:0] product
);

  localparam int PROD_W = 2 * RADIX;
  // Four terms offset by 0/20/40/60 bits need PW+60 bits plus two carry bits.
  localparam int ROW_W  = PW + 62;
  localparam int NPP    = 12;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] ROW0 = 3'd1;
  localparam logic [2:0] ROW1 = 3'd2;
  localparam logic [2:0] ROW2 = 3'd3;
  localparam logic [2:0] OUT  = 3'd4;

  logic [PW-1:0]     res_s [NPP];
  logic [PW-1:0]     cap_r [NPP];
  logic [2:0]        state_r;
  logic [2:0]        state_nx_s;
  logic [PROD_W-1:0] acc_r;
  logic [PROD_W-1:0] addend_s;
  logic [ROW_W-1:0]  row_s;
  logic [5:0]        row_shift_s;
  logic              out_valid_r;
  logic              in_xfer_s;
  logic              out_xfer_s;
  logic              in_row_s;

  function automatic logic [ROW_W-1:0] row_sum(
    input logic [PW-1:0] p0,
    input logic [PW-1:0] p1,
    input logic [PW-1:0] p2,
    input logic [PW-1:0] p3
  );
    row_sum = ROW_W'(p0)
            + (ROW_W'(p1) << 6'd20)
            + (ROW_W'(p2) << 6'd40)
            + (ROW_W'(p3) << 6'd60);
  endfunction

  assign res_s[0]  = res_0;
  assign res_s[1]  = res_1;
  assign res_s[2]  = res_2;
  assign res_s[3]  = res_3;
  assign res_s[4]  = res_4;
  assign res_s[5]  = res_5;
  assign res_s[6]  = res_6;
  assign res_s[7]  = res_7;
  assign res_s[8]  = res_8;
  assign res_s[9]  = res_9;
  assign res_s[10] = res_10;
  assign res_s[11] = res_11;

  assign in_ready   = (state_r == IDLE);
  assign in_xfer_s  = in_valid & in_ready;
  assign out_xfer_s = out_valid_r & out_ready;
  assign in_row_s   = (state_r == ROW0) | (state_r == ROW1) | (state_r == ROW2);
  assign out_valid  = out_valid_r;
  assign product    = acc_r;

  // Next-state decode for the row sequencer
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_xfer_s) state_nx_s = ROW0;
        else           state_nx_s = IDLE;
      end
      ROW0: state_nx_s = ROW1;
      ROW1: state_nx_s = ROW2;
      ROW2: state_nx_s = OUT;
      OUT: begin
        if (out_xfer_s) state_nx_s = IDLE;
        else            state_nx_s = OUT;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // Select the captured row for this cycle and its 26k-bit weight
  always_comb begin
    row_s       = '0;
    row_shift_s = 6'd0;
    case (state_r)
      ROW0: begin
        row_s       = row_sum(cap_r[0], cap_r[1], cap_r[2], cap_r[3]);
        row_shift_s = 6'd0;
      end
      ROW1: begin
        row_s       = row_sum(cap_r[4], cap_r[5], cap_r[6], cap_r[7]);
        row_shift_s = 6'd26;
      end
      ROW2: begin
        row_s       = row_sum(cap_r[8], cap_r[9], cap_r[10], cap_r[11]);
        row_shift_s = 6'd52;
      end
      default: begin
        row_s       = '0;
        row_shift_s = 6'd0;
      end
    endcase
    addend_s = PROD_W'(row_s) << row_shift_s;
  end

  // Sequencer state and registered result-valid flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      out_valid_r <= (state_nx_s == OUT);
    end
  end

  // Partial-product capture; only loaded on an accepted set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NPP; i++) cap_r[i] <= '0;
    end else if (in_xfer_s) begin
      for (int i = 0; i < NPP; i++) cap_r[i] <= res_s[i];
    end else begin
      for (int i = 0; i < NPP; i++) cap_r[i] <= cap_r[i];
    end
  end

  // Accumulator: cleared on capture, one row added per ROW state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= '0;
    end else if (in_xfer_s) begin
      acc_r <= '0;
    end else if (in_row_s) begin
      acc_r <= acc_r + addend_s;
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule
